// File: rtl/mtm_alu_tx_scheduler.sv
// mtm_alu_tx_scheduler
// Queues ALU data results in a small FIFO, holds one pending error response,
// and launches one frame at a time to the output serializer. A pending error
// always wins over queued data. Also reports queue level, frame count and a
// sticky protocol-fault flag.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   res_valid/res_ready   result handshake; res_ready = !full
//   res_C, res_CTL        result data / control (CTL bit7 must be 0)
//   err_valid/err_ready   error handshake; err_ready = !err_pend
//   err_CTL               error code (C9, 93, A5 are legal)
//   ser_C, ser_CTL        registered frame payload, stable between launches
//   ser_start             one-cycle launch pulse
//   ser_busy              serializer transmitting
//   fifo_level            FIFO occupancy 0..DEPTH
//   frames_sent           launched-frame counter (wraps)
//   proto_err             sticky: illegal input dropped or ack timeout
module mtm_alu_tx_scheduler #(
  parameter int DEPTH   = 4,
  parameter int AW      = 2,
  parameter int ACK_TMO = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          res_valid,
  output logic          res_ready,
  input  logic [31:0]   res_C,
  input  logic [7:0]    res_CTL,
  input  logic          err_valid,
  output logic          err_ready,
  input  logic [7:0]    err_CTL,
  output logic [31:0]   ser_C,
  output logic [7:0]    ser_CTL,
  output logic          ser_start,
  input  logic          ser_busy,
  output logic [AW:0]   fifo_level,
  output logic [15:0]   frames_sent,
  output logic          proto_err
);

  localparam int TW = $clog2(ACK_TMO + 1);

  typedef struct packed {
    logic [31:0] c;
    logic [7:0]  ctl;
  } entry_t;

  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  state_t        state;
  logic          err_pend;
  logic [7:0]    err_code;
  logic [TW-1:0] tmo;

  logic full, empty, res_fire, push, res_bad;
  logic err_legal, err_fire, err_take, err_bad, pop;
  entry_t head;

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign res_ready  = !full;
  assign err_ready  = !err_pend;
  assign fifo_level = count;
  assign head       = mem[rd_ptr];

  assign res_fire  = res_valid && res_ready;
  assign push      = res_fire && !res_CTL[7];
  assign res_bad   = res_fire && res_CTL[7];
  assign err_legal = (err_CTL == 8'hC9) || (err_CTL == 8'h93) || (err_CTL == 8'hA5);
  assign err_fire  = err_valid && err_ready;
  assign err_take  = err_fire && err_legal;
  assign err_bad   = err_fire && !err_legal;
  // Data is only popped when no error is waiting; the error goes first.
  assign pop       = (state == IDLE) && !err_pend && !empty;

  // Storage needs no reset: pointers/count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{c: res_C, ctl: res_CTL};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ser_C       <= '0;
      ser_CTL     <= '0;
      ser_start   <= 1'b0;
      frames_sent <= '0;
      proto_err   <= 1'b0;
      err_pend    <= 1'b0;
      err_code    <= '0;
      tmo         <= '0;
    end else begin
      ser_start <= 1'b0;
      // Capture and launch of the error slot are mutually exclusive
      // (capture needs the slot empty, launch needs it full).
      if (err_take) begin
        err_pend <= 1'b1;
        err_code <= err_CTL;
      end
      if (res_bad || err_bad) proto_err <= 1'b1;
      case (state)
        IDLE: begin
          if (err_pend) begin
            ser_C     <= '0;
            ser_CTL   <= err_code;
            err_pend  <= 1'b0;
            ser_start <= 1'b1;
            state     <= START;
          end else if (!empty) begin
            ser_C     <= head.c;
            ser_CTL   <= head.ctl;
            ser_start <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          frames_sent <= frames_sent + 16'd1;
          tmo         <= '0;
          state       <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (ser_busy) begin
            state <= WAIT_DONE;
          end else if (tmo == TW'(ACK_TMO - 1)) begin
            // Serializer never acknowledged: flag it, drop the frame.
            proto_err <= 1'b1;
            state     <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!ser_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mtm_alu_tx_scheduler.sv
// Self-checking bench for mtm_alu_tx_scheduler. A behavioural serializer
// drives ser_busy; a queue of expected frames is checked at every launch.
module tb_mtm_alu_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        res_valid, res_ready;
  logic [31:0] res_C;
  logic [7:0]  res_CTL;
  logic        err_valid, err_ready;
  logic [7:0]  err_CTL;
  logic [31:0] ser_C;
  logic [7:0]  ser_CTL;
  logic        ser_start;
  logic        ser_busy = 1'b0;
  logic [2:0]  fifo_level;
  logic [15:0] frames_sent;
  logic        proto_err;

  int checks = 0;
  int failures = 0;

  logic [39:0] exp_q[$];       // expected {C,CTL} of each launch, in order
  int busy_mode = 2;           // 0 auto, 1 force high, 2 force low
  int busy_len = 3;
  int bcnt = 0;

  always #5 clk = ~clk;

  mtm_alu_tx_scheduler #(.DEPTH(4), .AW(2), .ACK_TMO(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .res_valid(res_valid), .res_ready(res_ready), .res_C(res_C), .res_CTL(res_CTL),
    .err_valid(err_valid), .err_ready(err_ready), .err_CTL(err_CTL),
    .ser_C(ser_C), .ser_CTL(ser_CTL), .ser_start(ser_start), .ser_busy(ser_busy),
    .fifo_level(fifo_level), .frames_sent(frames_sent), .proto_err(proto_err)
  );

  // Serializer model: raise busy after seeing a launch, hold busy_len cycles.
  always @(posedge clk) begin
    if (busy_mode == 1) begin
      ser_busy <= 1'b1; bcnt <= 0;
    end else if (busy_mode == 2) begin
      ser_busy <= 1'b0; bcnt <= 0;
    end else if (ser_start) begin
      ser_busy <= 1'b1; bcnt <= busy_len;
    end else if (bcnt > 1) begin
      bcnt <= bcnt - 1;
    end else begin
      ser_busy <= 1'b0; bcnt <= 0;
    end
  end

  // Launch monitor: every ser_start must match the next expected frame.
  always @(negedge clk) begin
    if (rst_n && ser_start) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_launch got C=%h CTL=%h, expected no launch", ser_C, ser_CTL);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if ({ser_C, ser_CTL} !== e) begin
          failures++;
          $display("FAIL launch_frame got C=%h CTL=%h, expected C=%h CTL=%h",
                   ser_C, ser_CTL, e[39:8], e[7:0]);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; res_valid = 1'b0; err_valid = 1'b0;
    res_C = '0; res_CTL = '0; err_CTL = '0;
    busy_mode = 2;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1; busy_mode = 0; busy_len = 3;
  endtask

  // Offer one result; returns at the negedge after it was accepted.
  task automatic push_res(input logic [31:0] c, input logic [7:0] ctl);
    int n;
    res_valid = 1'b1; res_C = c; res_CTL = ctl;
    n = 0;
    while (!res_ready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while ((ser_busy || exp_q.size() != 0 || fifo_level != 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL %s_drain pending=%0d level=%0d, expected all frames launched",
               name, exp_q.size(), fifo_level);
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ser_C !== 32'd0) begin failures++; $display("FAIL reset_ser_C got %h want 0", ser_C); end
    checks++; if (ser_CTL !== 8'd0) begin failures++; $display("FAIL reset_ser_CTL got %h want 0", ser_CTL); end
    checks++; if (ser_start !== 1'b0) begin failures++; $display("FAIL reset_ser_start got %b want 0", ser_start); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (frames_sent !== 16'd0) begin failures++; $display("FAIL reset_frames got %0d want 0", frames_sent); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_proto got %b want 0", proto_err); end
    checks++; if (res_ready !== 1'b1 || err_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got res=%b err=%b want 1 1", res_ready, err_ready); end
  endtask

  task automatic test_single();
    do_reset();
    busy_len = 55;
    exp_q.push_back({32'h12345678, 8'h04});
    res_valid = 1'b1; res_C = 32'h12345678; res_CTL = 8'h04;
    checks++; if (res_ready !== 1'b1) begin failures++; $display("FAIL single_ready got %b want 1", res_ready); end
    @(negedge clk);
    res_valid = 1'b0;
    checks++; if (ser_start !== 1'b0) begin failures++; $display("FAIL single_early_start got %b want 0", ser_start); end
    @(negedge clk);
    checks++; if (ser_start !== 1'b1) begin failures++; $display("FAIL single_latency got start=%b want 1", ser_start); end
    wait_idle("single");
    checks++; if (frames_sent !== 16'd1) begin failures++; $display("FAIL single_frames got %0d want 1", frames_sent); end
    checks++; if (ser_C !== 32'h12345678 || ser_CTL !== 8'h04) begin
      failures++; $display("FAIL single_hold got %h/%h want 12345678/04", ser_C, ser_CTL); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL single_level got %0d want 0", fifo_level); end
  endtask

  task automatic test_backpressure();
    logic [31:0] c[5];
    logic [7:0]  t[5];
    int i, n, m;
    logic acc;
    do_reset();
    busy_mode = 1;
    for (int k = 0; k < 5; k++) begin
      c[k] = $urandom; t[k] = 8'($urandom) & 8'h7F;
      exp_q.push_back({c[k], t[k]});
    end
    i = 0; n = 0;
    while (i < 5 && n < 60) begin
      res_valid = 1'b1; res_C = c[i]; res_CTL = t[i];
      acc = res_ready;
      @(negedge clk);
      n++;
      if (acc) i++;
    end
    res_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (i != 5) begin failures++; $display("FAIL bp_accepted got %0d want 5", i); end
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL bp_full_level got %0d want 4", fifo_level); end
    checks++; if (res_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got %b want 0", res_ready); end
    busy_mode = 0; busy_len = 3;
    n = 0;
    while (ser_busy && n < 20) begin @(negedge clk); n++; end
    m = 0;
    while (!ser_start && m < 20) begin @(negedge clk); m++; end
    checks++; if (m != 2) begin failures++; $display("FAIL bp_release_latency got %0d want 2", m); end
    wait_idle("bp");
    checks++; if (frames_sent !== 16'd5) begin failures++; $display("FAIL bp_frames got %0d want 5", frames_sent); end
  endtask

  task automatic test_priority();
    logic [31:0] a, b, d;
    do_reset();
    busy_len = 20;
    a = $urandom; b = $urandom; d = $urandom;
    exp_q.push_back({a, 8'h11});
    exp_q.push_back({32'd0, 8'hC9});
    exp_q.push_back({b, 8'h22});
    exp_q.push_back({d, 8'h33});
    push_res(a, 8'h11);
    push_res(b, 8'h22);
    push_res(d, 8'h33);
    @(negedge clk);
    checks++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL prio_level got %0d want 2", fifo_level); end
    err_valid = 1'b1; err_CTL = 8'hC9;
    checks++; if (err_ready !== 1'b1) begin failures++; $display("FAIL prio_err_ready got %b want 1", err_ready); end
    @(negedge clk);
    err_valid = 1'b0;
    checks++; if (err_ready !== 1'b0) begin failures++; $display("FAIL prio_err_pend got ready=%b want 0", err_ready); end
    wait_idle("prio");
    checks++; if (frames_sent !== 16'd4) begin failures++; $display("FAIL prio_frames got %0d want 4", frames_sent); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL prio_proto got %b want 0", proto_err); end
  endtask

  task automatic test_illegal();
    do_reset();
    push_res($urandom, 8'h85);
    repeat (10) @(negedge clk);
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL illegal_res_proto got %b want 1", proto_err); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL illegal_res_level got %0d want 0", fifo_level); end
    do_reset();
    err_valid = 1'b1; err_CTL = 8'hFF;
    @(negedge clk);
    err_valid = 1'b0;
    checks++; if (err_ready !== 1'b1) begin failures++; $display("FAIL illegal_err_ready got %b want 1", err_ready); end
    repeat (10) @(negedge clk);
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL illegal_err_proto got %b want 1", proto_err); end
    checks++; if (frames_sent !== 16'd0) begin failures++; $display("FAIL illegal_frames got %0d want 0", frames_sent); end
  endtask

  task automatic test_timeout();
    logic [31:0] x, y;
    int m;
    do_reset();
    busy_mode = 2;
    x = $urandom; y = $urandom;
    exp_q.push_back({x, 8'h05});
    exp_q.push_back({y, 8'h06});
    push_res(x, 8'h05);
    push_res(y, 8'h06);
    checks++; if (ser_start !== 1'b1) begin failures++; $display("FAIL tmo_first_start got %b want 1", ser_start); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL tmo_early_proto got %b want 0", proto_err); end
    m = 0;
    do begin @(negedge clk); m++; end while (!ser_start && m < 30);
    checks++; if (m != 6) begin failures++; $display("FAIL tmo_gap got %0d want 6", m); end
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL tmo_proto got %b want 1", proto_err); end
    wait_idle("tmo");
    checks++; if (frames_sent !== 16'd2) begin failures++; $display("FAIL tmo_frames got %0d want 2", frames_sent); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] z;
    int n;
    do_reset();
    busy_len = 40;
    for (int k = 0; k < 4; k++) begin
      z = $urandom;
      exp_q.push_back({z, 8'(k)});
      push_res(z, 8'(k));
    end
    n = 0;
    while (!ser_busy && n < 20) begin @(negedge clk); n++; end
    checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL mid_level got %0d want 3", fifo_level); end
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++; if (ser_C !== 32'd0 || ser_CTL !== 8'd0 || ser_start !== 1'b0) begin
      failures++; $display("FAIL mid_ser got %h/%h/%b want 0/0/0", ser_C, ser_CTL, ser_start); end
    checks++; if (fifo_level !== 3'd0 || frames_sent !== 16'd0 || proto_err !== 1'b0) begin
      failures++; $display("FAIL mid_status got lvl=%0d frames=%0d proto=%b want 0", fifo_level, frames_sent, proto_err); end
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    checks++; if (frames_sent !== 16'd0) begin failures++; $display("FAIL mid_no_launch got %0d want 0", frames_sent); end
    z = $urandom;
    exp_q.push_back({z, 8'h2A});
    push_res(z, 8'h2A);
    wait_idle("mid");
    checks++; if (frames_sent !== 16'd1) begin failures++; $display("FAIL mid_frames got %0d want 1", frames_sent); end
  endtask

  task automatic test_random();
    logic [7:0] ctl;
    logic [31:0] c;
    int nlegal;
    logic expp;
    do_reset();
    nlegal = 0; expp = 1'b0;
    for (int it = 0; it < 200; it++) begin
      busy_len = $urandom_range(1, 6);
      if ($urandom_range(0, 2) != 0) begin
        c = $urandom; ctl = 8'($urandom);
        ctl[7] = ($urandom_range(0, 7) == 0);
        res_valid = 1'b1; res_C = c; res_CTL = ctl;
        if (res_ready) begin
          if (ctl[7]) expp = 1'b1;
          else begin exp_q.push_back({c, ctl}); nlegal++; end
        end
      end else begin
        res_valid = 1'b0;
      end
      @(negedge clk);
    end
    res_valid = 1'b0;
    wait_idle("rand");
    checks++; if (frames_sent !== 16'(nlegal)) begin failures++; $display("FAIL rand_frames got %0d want %0d", frames_sent, nlegal); end
    checks++; if (proto_err !== expp) begin failures++; $display("FAIL rand_proto got %b want %b", proto_err, expp); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL rand_level got %0d want 0", fifo_level); end
  endtask

  initial begin
    rst_n = 1'b0; res_valid = 1'b0; err_valid = 1'b0;
    res_C = '0; res_CTL = '0; err_CTL = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_priority();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mtm_alu_tx_scheduler.md
Name: mtm_alu_tx_scheduler

Overview:
Sits between the ALU core and the output serializer. Queues data results (32-bit C plus CTL byte) in a small FIFO and holds one pending error response. It arbitrates between the two with error priority, and launches one frame at a time to the serializer over a start/busy handshake. It also reports queue level, frame count and sticky protocol faults.

Parameters:
DEPTH, 4, result FIFO entries; power of two, at least 2
AW, 2, log2(DEPTH)
ACK_TMO, 4, max cycles in WAIT_ACK for ser_busy to rise

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
res_valid  in  1  result offered by ALU core
res_ready  out  1  FIFO can accept; equals !full (combinational)
res_C  in  32  result data
res_CTL  in  8  result control byte; bit7 must be 0
err_valid  in  1  error response offered
err_ready  out  1  error slot free; equals !err_pend
err_CTL  in  8  error code; legal values 8'hC9, 8'h93, 8'hA5
ser_C  out  32  frame data to serializer (registered)
ser_CTL  out  8  frame control byte to serializer (registered)
ser_start  out  1  one-cycle launch pulse (registered)
ser_busy  in  1  serializer transmitting
fifo_level  out  AW+1  current FIFO occupancy, 0..DEPTH
frames_sent  out  16  count of launched frames; wraps at 16'hFFFF->0
proto_err  out  1  sticky: illegal input dropped or ack timeout

Behaviour:
- Reset values: ser_C=0, ser_CTL=0, ser_start=0, fifo_level=0, frames_sent=0, proto_err=0, err_pend=0. FSM goes to IDLE and FIFO pointers to 0. Reset mid-frame aborts it; queued items are discarded.
- FIFO push when res_valid && res_ready && res_CTL[7]==0.
- If res_valid && res_ready && res_CTL[7]==1, the item is dropped and proto_err is set.
- Push and pop in the same cycle is legal: level unchanged, pointers wrap modulo DEPTH. Push while full cannot occur because res_ready is 0.
- Error slot capture when err_valid && err_ready && err_CTL is a legal code: err_pend=1 and the code is stored.
- An illegal err_CTL is dropped and sets proto_err. err_ready stays 1.
- FSM states: IDLE, START, WAIT_ACK, WAIT_DONE.
- IDLE:
  - If err_pend: ser_CTL<=stored code, ser_C<=0, clear err_pend, go to START.
  - Else if FIFO not empty: ser_C/ser_CTL<=head, pop, go to START.
  - Else stay. Error always wins over a non-empty FIFO.
- START: ser_start=1 for exactly this cycle; frames_sent++; reset the timeout counter; go to WAIT_ACK.
- WAIT_ACK:
  - ser_busy==1 -> WAIT_DONE.
  - Timeout counter reaches ACK_TMO -> set proto_err, go to IDLE. The frame counts as sent and is not retried.
- WAIT_DONE: ser_busy==0 -> IDLE.
- ser_C/ser_CTL change only on the IDLE->START transition and stay stable until the next launch.
- Latency: item accepted at edge k with FSM in IDLE and no competitor -> ser_start high during the cycle after edge k+1. Back-to-back frames are separated by at least one IDLE cycle after ser_busy falls.
- err_valid arriving in the same cycle IDLE selects a FIFO item: the FIFO item launches; the error is captured and launches next.
- err_pend clears at launch, so a new error may be accepted during WAIT_ACK/WAIT_DONE.
- proto_err clears only on reset.

Test Plan:
- Single result: push C=32'h12345678, CTL=8'h04; serializer model holds busy for 55 cycles -> one ser_start pulse 2 cycles after push, ser_C=32'h12345678, ser_CTL=8'h04, frames_sent=1, fifo_level returns to 0.
- Fill and backpressure: busy held high, push 5 results -> first launches and fifo_level reaches 4 with res_ready=0. Releasing busy drains the items in order, each launch one cycle after busy falls plus IDLE.
- Priority: FIFO holds 2 items during a frame, then err_CTL=8'hC9 accepted -> the next launch has ser_CTL=8'hC9, ser_C=0, followed by both FIFO items in order.
- Illegal inputs: res_CTL=8'h85 and err_CTL=8'hFF -> neither queued, proto_err=1, no ser_start.
- Ack timeout: ser_busy tied 0 -> WAIT_ACK exits after 4 cycles, proto_err=1, next item still launches.
- Reset mid-frame: rst_n low during WAIT_DONE with 3 items queued -> next cycle all outputs at reset values, fifo_level=0; no launch after release until a new push.
